wb_host_loader: RTL and testbench

- Wishbone initiator that drives the mainboard's byte-wide debug/loader slave port (VDP RAM, console ROM, GROM, cartridge ROM windows).
- Converts a host byte stream (UART/SPI bridge side) into single-byte Wishbone read and write cycles with an auto-incrementing 24-bit address.
- Read data is returned on an outbound byte stream.
- Sits between the host link and the mainboard's wb_* inputs; one instance per system.

---
 rtl/wb_host_loader.sv | 182 ++++++++++++++++++
 tb/tb_wb_host_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_host_loader.sv
// wb_host_loader: host byte-stream to Wishbone byte initiator.
// Header is opcode, 24-bit address, 16-bit length (all MSB first), then data
// bytes for writes. Each byte becomes one single-beat Wishbone cycle at an
// auto-incrementing address; read data is returned on the tx stream.
module wb_host_loader #(
  parameter int timeout_cycles = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [23:0] wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  output logic        wb_we_o,
  output logic [0:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  output logic        busy,
  output logic        err
);

  localparam int TW = $clog2(timeout_cycles + 1);
  // Value of the stb-cycle counter on the last clock a slave may still ack.
  localparam logic [TW-1:0] TMO_LAST = TW'(timeout_cycles - 1);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_WDATA, S_WBUS, S_RBUS, S_RSEND
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_hcnt;
  logic            r_wr;
  logic [23:0]     r_adr;
  logic [15:0]     r_cnt;
  logic [7:0]      r_wdat;
  logic [7:0]      r_txd;
  logic            r_err;
  logic [TW-1:0]   r_tmo;

  logic            w_rx_acc;
  logic            w_tx_acc;
  logic            w_tmo_hit;
  logic            w_bus_done;
  logic            w_last;
  logic            w_len_zero;

  assign w_rx_acc   = rx_valid & rx_ready;
  assign w_tx_acc   = tx_valid & tx_ready;
  assign w_tmo_hit  = (r_tmo == TMO_LAST);
  // Ack and timeout on the same edge both end the cycle; ack takes priority
  // in the datapath so err stays clear.
  assign w_bus_done = wb_ack_i | w_tmo_hit;
  assign w_last     = (r_cnt == 16'd1);
  assign w_len_zero = ({r_cnt[15:8], rx_data} == 16'd0);

  assign tx_data  = r_txd;
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_wdat;
  assign err      = r_err;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_rx_acc && (rx_data == OP_WRITE || rx_data == OP_READ))
                 w_next = S_HDR;
      S_HDR:   if (w_rx_acc && r_hcnt == 3'd4) begin
                 if (w_len_zero) w_next = S_IDLE;
                 else if (r_wr)  w_next = S_WDATA;
                 else            w_next = S_RBUS;
               end
      S_WDATA: if (w_rx_acc) w_next = S_WBUS;
      S_WBUS:  if (w_bus_done) w_next = w_last ? S_IDLE : S_WDATA;
      S_RBUS:  if (w_bus_done) w_next = S_RSEND;
      S_RSEND: if (w_tx_acc) w_next = w_last ? S_IDLE : S_RBUS;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state; rx_ready is forced low in reset.
  always_comb begin
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_sel_o = 1'b0;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE, S_HDR, S_WDATA: rx_ready = reset_n;
      S_WBUS: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_sel_o = 1'b1;
        wb_we_o  = 1'b1;
      end
      S_RBUS: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_sel_o = 1'b1;
      end
      S_RSEND: tx_valid = 1'b1;
      default: ;
    endcase
  end

  // Header capture, address/count bookkeeping, timeout counting and sticky err.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hcnt <= '0;
      r_wr   <= 1'b0;
      r_adr  <= '0;
      r_cnt  <= '0;
      r_wdat <= '0;
      r_txd  <= '0;
      r_err  <= 1'b0;
      r_tmo  <= '0;
    end else begin
      r_tmo <= '0;
      case (r_state)
        S_IDLE: if (w_rx_acc) begin
          r_err  <= 1'b0;
          r_wr   <= (rx_data == OP_WRITE);
          r_hcnt <= '0;
        end
        S_HDR: if (w_rx_acc) begin
          r_hcnt <= r_hcnt + 3'd1;
          case (r_hcnt)
            3'd0:    r_adr[23:16] <= rx_data;
            3'd1:    r_adr[15:8]  <= rx_data;
            3'd2:    r_adr[7:0]   <= rx_data;
            3'd3:    r_cnt[15:8]  <= rx_data;
            default: r_cnt[7:0]   <= rx_data;
          endcase
        end
        S_WDATA: if (w_rx_acc) r_wdat <= rx_data;
        S_WBUS: begin
          r_tmo <= r_tmo + 1'b1;
          if (w_bus_done) begin
            // A timed-out write is dropped but still consumes its slot.
            if (!wb_ack_i) r_err <= 1'b1;
            r_adr <= r_adr + 24'd1;
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_RBUS: begin
          r_tmo <= r_tmo + 1'b1;
          if (w_bus_done) begin
            if (wb_ack_i) begin
              r_txd <= wb_dat_i;
            end else begin
              r_txd <= 8'hFF;
              r_err <= 1'b1;
            end
          end
        end
        S_RSEND: if (w_tx_acc) begin
          r_adr <= r_adr + 24'd1;
          r_cnt <= r_cnt - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_loader.sv
// Directed bench for wb_host_loader with a small Wishbone slave model.
module tb_wb_host_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [23:0] wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i;
  logic        wb_we_o;
  logic [0:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i = 1'b0;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;

  wb_host_loader #(.timeout_cycles(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Slave read contents.
  function automatic logic [7:0] slave_rd(input logic [23:0] a);
    case (a)
      24'h020000: slave_rd = 8'h12;
      24'h020001: slave_rd = 8'h34;
      24'h030000: slave_rd = 8'h5A;
      default:    slave_rd = a[7:0] ^ 8'hC3;
    endcase
  endfunction
  assign wb_dat_i = slave_rd(wb_adr_o);

  // Slave model: acks after ack_delay stb cycles, logs writes, tracks stability.
  bit          ack_en = 1'b1;
  int          ack_delay = 2;
  bit          prev_stb = 1'b0;
  int          stb_len = 0;
  int          cyc_starts = 0;
  int          unstable = 0;
  int          tx_seen = 0;
  logic [23:0] cap_adr = '0;
  logic [7:0]  cap_dat = '0;
  logic        cap_we = 1'b0;
  int          log_n = 0;
  logic [23:0] log_adr [0:15];
  logic [7:0]  log_dat [0:15];
  logic        log_we  [0:15];
  logic [0:0]  log_sel [0:15];

  always @(negedge clk) begin
    if (wb_stb_o) begin
      if (!prev_stb) begin
        stb_len = 1;
        cyc_starts++;
        cap_adr = wb_adr_o;
        cap_dat = wb_dat_o;
        cap_we  = wb_we_o;
      end else begin
        stb_len++;
        if (wb_adr_o !== cap_adr || wb_dat_o !== cap_dat || wb_we_o !== cap_we ||
            wb_cyc_o !== 1'b1 || wb_sel_o !== 1'b1)
          unstable++;
      end
      if (ack_en && stb_len == ack_delay) begin
        wb_ack_i = 1'b1;
        if (wb_we_o && log_n < 16) begin
          log_adr[log_n] = wb_adr_o;
          log_dat[log_n] = wb_dat_o;
          log_we[log_n]  = wb_we_o;
          log_sel[log_n] = wb_sel_o;
          log_n++;
        end
      end else begin
        wb_ack_i = 1'b0;
      end
    end else begin
      wb_ack_i = 1'b0;
    end
    prev_stb = wb_stb_o;
    if (tx_valid) tx_seen++;
  end

  // Offer one byte from a falling edge; returns on the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (rx_ready) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL rx_accept: byte %h never accepted", b);
    end
  endtask

  task automatic wait_tx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tx_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic accept_tx();
    tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin idle = 1'b1; break; end
      @(negedge clk);
    end
    if (!idle) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy=%b want 0 within bound", busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_ready, tx_valid, busy, err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: rx_ready/tx_valid/busy/err=%b want 0000", {rx_ready, tx_valid, busy, err});
    end
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_bus: cyc/stb/we/sel=%b want 0000", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o});
    end
    checks++;
    if ({wb_adr_o, wb_dat_o, tx_data} !== 40'h0) begin
      errors++;
      $display("FAIL reset_data: adr=%h dat=%h tx=%h want 0", wb_adr_o, wb_dat_o, tx_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_rx_ready: got %b want 1", rx_ready);
    end
  endtask

  task automatic test_write();
    int base_tx = tx_seen;
    ack_en = 1'b1; ack_delay = 2; log_n = 0; unstable = 0;
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB);
    wait_idle();
    checks++;
    if (log_n !== 2) begin
      errors++; $display("FAIL wr_count: got %0d writes want 2", log_n);
    end
    checks++;
    if (log_adr[0] !== 24'h010010 || log_dat[0] !== 8'hAA || log_we[0] !== 1'b1 || log_sel[0] !== 1'b1) begin
      errors++;
      $display("FAIL wr_first: adr=%h dat=%h we=%b sel=%b want 010010 AA 1 1", log_adr[0], log_dat[0], log_we[0], log_sel[0]);
    end
    checks++;
    if (log_adr[1] !== 24'h010011 || log_dat[1] !== 8'hBB || log_we[1] !== 1'b1) begin
      errors++;
      $display("FAIL wr_second: adr=%h dat=%h we=%b want 010011 BB 1", log_adr[1], log_dat[1], log_we[1]);
    end
    checks++;
    if (tx_seen !== base_tx || err !== 1'b0 || unstable !== 0) begin
      errors++;
      $display("FAIL wr_side: tx_cycles=%0d err=%b unstable=%0d want 0 0 0", tx_seen - base_tx, err, unstable);
    end
  endtask

  task automatic test_read_backpressure();
    bit ok;
    int base_cyc = cyc_starts;
    int bad = 0;
    ack_en = 1'b1; ack_delay = 1; unstable = 0;
    send_byte(8'h52); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    wait_tx(ok);
    checks++;
    if (!ok || tx_data !== 8'h12) begin
      errors++; $display("FAIL rd_first: valid=%b data=%h want 1 12", ok, tx_data);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'h12) bad++;
    end
    checks++;
    if (bad !== 0 || cyc_starts - base_cyc !== 1) begin
      errors++;
      $display("FAIL rd_hold: unstable=%0d bus_cycles=%0d want 0 1", bad, cyc_starts - base_cyc);
    end
    accept_tx();
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++; $display("FAIL rd_drop: tx_valid=%b want 0", tx_valid);
    end
    wait_tx(ok);
    checks++;
    if (!ok || tx_data !== 8'h34) begin
      errors++; $display("FAIL rd_second: valid=%b data=%h want 1 34", ok, tx_data);
    end
    accept_tx();
    wait_idle();
    checks++;
    if (cyc_starts - base_cyc !== 2 || err !== 1'b0 || unstable !== 0) begin
      errors++;
      $display("FAIL rd_end: bus_cycles=%0d err=%b unstable=%0d want 2 0 0", cyc_starts - base_cyc, err, unstable);
    end
  endtask

  task automatic test_wrap_zero();
    int base_cyc;
    int base_tx;
    ack_en = 1'b1; ack_delay = 1; log_n = 0;
    send_byte(8'h57); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    wait_idle();
    checks++;
    if (log_n !== 2 || log_adr[0] !== 24'hFFFFFF || log_dat[0] !== 8'h11 ||
        log_adr[1] !== 24'h000000 || log_dat[1] !== 8'h22) begin
      errors++;
      $display("FAIL wrap: n=%0d %h/%h %h/%h want 2 FFFFFF/11 000000/22", log_n, log_adr[0], log_dat[0], log_adr[1], log_dat[1]);
    end
    base_cyc = cyc_starts;
    base_tx = tx_seen;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL zero_len_busy: got %b want 0", busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cyc_starts !== base_cyc || tx_seen !== base_tx) begin
      errors++;
      $display("FAIL zero_len_bus: bus_cycles=%0d tx_cycles=%0d want 0 0", cyc_starts - base_cyc, tx_seen - base_tx);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    ack_en = 1'b0;
    send_byte(8'h52); send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    wait_tx(ok);
    checks++;
    if (!ok || tx_data !== 8'hFF || err !== 1'b1 || stb_len !== 16) begin
      errors++;
      $display("FAIL timeout: valid=%b data=%h err=%b stb_len=%0d want 1 FF 1 16", ok, tx_data, err, stb_len);
    end
    accept_tx();
    wait_idle();
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b want 1", err);
    end
    ack_en = 1'b1; ack_delay = 16;
    send_byte(8'h52);
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_clear: got %b want 0", err);
    end
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h01);
    wait_tx(ok);
    checks++;
    if (!ok || tx_data !== 8'h5A || err !== 1'b0 || stb_len !== 16) begin
      errors++;
      $display("FAIL ack_vs_timeout: valid=%b data=%h err=%b stb_len=%0d want 1 5A 0 16", ok, tx_data, err, stb_len);
    end
    accept_tx();
    wait_idle();
  endtask

  task automatic test_reset_mid_op();
    int base_cyc;
    ack_en = 1'b0;
    send_byte(8'h57); send_byte(8'h04); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h77); send_byte(8'h88);
    checks++;
    if (wb_stb_o !== 1'b1 || err !== 1'b1) begin
      errors++; $display("FAIL pre_reset: stb=%b err=%b want 1 1", wb_stb_o, err);
    end
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({wb_cyc_o, wb_stb_o, busy, tx_valid, err, rx_ready} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset: cyc/stb/busy/tx_valid/err/rx_ready=%b want 000000",
               {wb_cyc_o, wb_stb_o, busy, tx_valid, err, rx_ready});
    end
    reset_n = 1'b1;
    @(negedge clk);
    ack_en = 1'b1; ack_delay = 1;
    base_cyc = cyc_starts;
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cyc_starts !== base_cyc || wb_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL unknown_op: busy=%b bus_cycles=%0d cyc=%b want 0 0 0", busy, cyc_starts - base_cyc, wb_cyc_o);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_read_backpressure();
    test_wrap_zero();
    test_timeout();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
